divider32: RTL and testbench

DIVIDER32 -- requirements
Module: divider32

---
 rtl/divider32.sv | 182 ++++++++++++++++++
 tb/tb_divider32.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider32.sv
`default_nettype none
// ============================================================================
// divider32 : 32-bit sequential restoring divider, one quotient bit per cycle.
// Optional signed mode enabled by defining DIVIDER32_SIGNED_EN.
// Revision  : 1.0
// ============================================================================

module divider32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef DIVIDER32_SIGNED_EN
  input  logic        sgn,
`endif
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        busy,
  output logic        done,
  output logic        V,
  output logic        DZ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] a_q, a_d;
  logic        dz_pend_q, dz_pend_d;
  logic        ovf_q, ovf_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rmd_q, rmd_d;
  logic        v_q, v_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        signed_mode;
`ifdef DIVIDER32_SIGNED_EN
  assign signed_mode = sgn;
`else
  assign signed_mode = 1'b0;
`endif

  // Operands are reduced to magnitudes at capture; signs are reapplied at DONE.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = signed_mode & A[31];
  assign b_neg = signed_mode & B[31];
  assign a_mag = a_neg ? (32'd0 - A) : A;
  assign b_mag = b_neg ? (32'd0 - B) : B;

  // rem_sh can reach 33 bits; the compare is the borrow of the 33-bit subtract.
  logic [32:0] rem_sh;
  logic        no_borrow;
  logic [31:0] trial;
  assign rem_sh    = {rem_q, dvd_q[31]};
  assign no_borrow = (rem_sh >= {1'b0, dvs_q});
  assign trial     = rem_sh[31:0] - dvs_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    dz_pend_d = dz_pend_q;
    ovf_d     = ovf_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    v_d       = v_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = A;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = 32'd0;
          cnt_d     = 5'd0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          ovf_d     = signed_mode && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
          dz_pend_d = (B == 32'd0);
          state_d   = (B == 32'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = no_borrow ? trial : rem_sh[31:0];
        dvd_d = {dvd_q[30:0], no_borrow};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_pend_q) begin
          quo_d = 32'hFFFF_FFFF;
          rmd_d = a_q;
          dz_d  = 1'b1;
          v_d   = 1'b0;
        end else begin
          quo_d = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
          rmd_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
          dz_d  = 1'b0;
          v_d   = ovf_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy also covers the done pulse cycle, while the FSM is already idle
    busy_d = (state_d != S_IDLE) | done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      a_q       <= 32'd0;
      dz_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= 32'd0;
      rmd_q     <= 32'd0;
      v_q       <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      a_q       <= a_d;
      dz_pend_q <= dz_pend_d;
      ovf_q     <= ovf_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      v_q       <= v_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign Q    = quo_q;
  assign R    = rmd_q;
  assign V    = v_q;
  assign DZ   = dz_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_divider32.sv
`default_nettype none
// ============================================================================
// tb_divider32 : self-checking bench for divider32 (directed table + random).
// Revision     : 1.0
// ============================================================================

module tb_divider32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        sgn;
  logic [31:0] Q, R;
  logic        busy, done, V, DZ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef DIVIDER32_SIGNED_EN
    .sgn   (sgn),
`endif
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .V     (V),
    .DZ    (DZ)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        v;
    logic        dz;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer division with the documented special cases.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic v, output logic dz);
    int sa, sb;
    v  = 1'b0;
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
        v = 1'b1;
      end else begin
        sa = int'(a);
        sb = int'(b);
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat counts edges after accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit immediate,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic v, output logic dz, output int lat, output int bcnt);
    if (!immediate) @(negedge clk);
    A     = a;
    B     = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) bcnt++;
    q  = Q;
    r  = R;
    v  = V;
    dz = DZ;
  endtask

  task automatic check_op(input string tag, input logic [31:0] q, input logic [31:0] r,
                          input logic v, input logic dz, input int lat, input int bcnt,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ev, input logic edz);
    int exp_lat;
    exp_lat = edz ? 1 : 33;
    check({tag, ".Q"}, q, eq);
    check({tag, ".R"}, r, er);
    check({tag, ".V"}, 32'(v), 32'(ev));
    check({tag, ".DZ"}, 32'(dz), 32'(edz));
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'(exp_lat + 1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".Q"}, Q, 32'd0);
    check({tag, ".R"}, R, 32'd0);
    check({tag, ".V"}, 32'(V), 32'd0);
    check({tag, ".DZ"}, 32'(DZ), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, ra, rb, eq, er;
    logic        v, dz, ev, edz;
    int          lat, bcnt, ndone, k;

    tbl.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,    1'b0, 1'b0});
    tbl.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,    1'b0, 1'b0});
    tbl.push_back('{32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5,    1'b0, 1'b0});
    tbl.push_back('{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234, 1'b0, 1'b1});
    tbl.push_back('{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,    1'b0, 1'b0});
    tbl.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,    1'b0, 1'b0});
    tbl.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,    1'b0, 1'b0});
    tbl.push_back('{32'h8000_0000,  32'd3,          1'b0, 32'd715827882,  32'd2,    1'b0, 1'b0});
    tbl.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000, 1'b0, 1'b0});
`ifdef DIVIDER32_SIGNED_EN
    tbl.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 1'b0});
    tbl.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,    1'b1, 1'b0});
    tbl.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,    1'b0, 1'b0});
    tbl.push_back('{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9, 1'b0, 1'b1});
`endif

    rst   = 1'b1;
    start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    sgn   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Every entry after the first issues start in the done cycle of the previous one.
    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, (i > 0), q, r, v, dz, lat, bcnt);
      check_op($sformatf("vec%0d", i), q, r, v, dz, lat, bcnt,
               tbl[i].q, tbl[i].r, tbl[i].v, tbl[i].dz);
    end

    repeat (5) @(negedge clk);
    check("hold.Q", Q, tbl[tbl.size()-1].q);
    check("hold.R", R, tbl[tbl.size()-1].r);

    // start during CALC with other operands must be dropped
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    A     = 32'd50;
    B     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("midstart.done_seen", 32'(done), 32'd1);
    check("midstart.Q", Q, 32'd14);
    check("midstart.R", R, 32'd2);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midstart.no_queue", 32'(ndone), 32'd0);

    // reset in the middle of CALC aborts without a done pulse
    A     = 32'd9999;
    B     = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    do_op(32'd9, 32'd3, 1'b0, 1'b0, q, r, v, dz, lat, bcnt);
    check_op("after_abort", q, r, v, dz, lat, bcnt, 32'd3, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = 32'($urandom_range(1, 255));
        4:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
`ifdef DIVIDER32_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      model(ra, rb, sgn, eq, er, ev, edz);
      do_op(ra, rb, sgn, ($urandom_range(0, 1) == 1), q, r, v, dz, lat, bcnt);
      check_op($sformatf("rnd%0d", i), q, r, v, dz, lat, bcnt, eq, er, ev, edz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
